// File: rtl/updown_counter_scheduler_if.sv
// ----------------------------------------------------------------------------
// updown_counter_scheduler_if
//   Bundle of the two requester command channels, the shared counter control
//   and feedback, and the completion report.
//   master : the environment (requesters + counter instance)
//   slave  : the scheduler
//   req{0,1}_valid/up/clear/steps  command from requester N
//   req{0,1}_ready                 command accepted this cycle
//   cnt_value                      counter output fed back
//   cnt_enable/cnt_up_down/cnt_reset  counter controls
//   busy, done, done_id, done_value   status / completion report
// ----------------------------------------------------------------------------
interface updown_counter_scheduler_if #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 4
);
   logic              req0_valid, req0_ready, req0_up, req0_clear;
   logic [STEP_W-1:0] req0_steps;
   logic              req1_valid, req1_ready, req1_up, req1_clear;
   logic [STEP_W-1:0] req1_steps;
   logic [WIDTH-1:0]  cnt_value;
   logic              cnt_enable, cnt_up_down, cnt_reset;
   logic              busy, done, done_id;
   logic [WIDTH-1:0]  done_value;

   modport master (
      output req0_valid, req0_up, req0_clear, req0_steps,
      output req1_valid, req1_up, req1_clear, req1_steps,
      output cnt_value,
      input  req0_ready, req1_ready,
      input  cnt_enable, cnt_up_down, cnt_reset,
      input  busy, done, done_id, done_value
   );

   modport slave (
      input  req0_valid, req0_up, req0_clear, req0_steps,
      input  req1_valid, req1_up, req1_clear, req1_steps,
      input  cnt_value,
      output req0_ready, req1_ready,
      output cnt_enable, cnt_up_down, cnt_reset,
      output busy, done, done_id, done_value
   );
endinterface

// File: rtl/updown_counter_scheduler.sv
// ----------------------------------------------------------------------------
// updown_counter_scheduler
//   Shares one up/down counter between two requesters. A round-robin arbiter
//   accepts one command at a time; an FSM then drives the counter's
//   enable/direction/clear and reports the resulting count with a one-cycle
//   done pulse.
//   clk   : clock, all state changes on posedge
//   reset : asynchronous, active-high
//   bus   : slave side of updown_counter_scheduler_if (commands, counter
//           control/feedback, completion report)
// ----------------------------------------------------------------------------
module updown_counter_scheduler #(
   parameter int WIDTH  = 4,
   parameter int STEP_W = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   updown_counter_scheduler_if.slave     bus
);

   typedef enum logic [1:0] {IDLE, RUN, CLEAR, SETTLE} state_t;

   state_t            r_state;
   logic              r_rr_last;
   logic              r_id;
   logic [STEP_W-1:0] r_remaining;
   logic              r_cnt_enable, r_cnt_up_down, r_cnt_reset;
   logic              r_done, r_done_id;
   logic [WIDTH-1:0]  r_done_value;

   logic              w_idle, w_gnt0, w_gnt1, w_hs;
   logic              w_sel_up, w_sel_clear;
   logic [STEP_W-1:0] w_sel_steps;

   // On a tie the requester that did not win last time is granted.
   assign w_idle = (r_state == IDLE);
   assign w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_rr_last);
   assign w_gnt0 = bus.req0_valid & ~w_gnt1;

   // Ready is held low during reset so no command is lost while the FSM is held.
   assign bus.req0_ready = w_idle & w_gnt0 & ~reset;
   assign bus.req1_ready = w_idle & w_gnt1 & ~reset;
   assign w_hs           = bus.req0_ready | bus.req1_ready;

   assign w_sel_up    = w_gnt1 ? bus.req1_up    : bus.req0_up;
   assign w_sel_clear = w_gnt1 ? bus.req1_clear : bus.req0_clear;
   assign w_sel_steps = w_gnt1 ? bus.req1_steps : bus.req0_steps;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_rr_last     <= 1'b1;
         r_id          <= 1'b0;
         r_remaining   <= '0;
         r_cnt_enable  <= 1'b0;
         r_cnt_up_down <= 1'b0;
         r_cnt_reset   <= 1'b0;
         r_done        <= 1'b0;
         r_done_id     <= 1'b0;
         r_done_value  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_hs) begin
                  r_id      <= w_gnt1;
                  r_rr_last <= w_gnt1;
                  if (w_sel_clear) begin
                     r_state     <= CLEAR;
                     r_cnt_reset <= 1'b1;
                  end else if (w_sel_steps == '0) begin
                     r_state <= SETTLE;
                  end else begin
                     r_state       <= RUN;
                     r_remaining   <= w_sel_steps;
                     r_cnt_enable  <= 1'b1;
                     r_cnt_up_down <= w_sel_up;
                  end
               end
            end
            RUN: begin
               // The last enabled cycle is the one that sees remaining==1.
               if (r_remaining == STEP_W'(1)) begin
                  r_state       <= SETTLE;
                  r_cnt_enable  <= 1'b0;
                  r_cnt_up_down <= 1'b0;
               end else begin
                  r_remaining <= r_remaining - STEP_W'(1);
               end
            end
            CLEAR: begin
               r_state     <= SETTLE;
               r_cnt_reset <= 1'b0;
            end
            SETTLE: begin
               // Counter has absorbed its final update; report it.
               r_state      <= IDLE;
               r_done       <= 1'b1;
               r_done_id    <= r_id;
               r_done_value <= bus.cnt_value;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.cnt_enable  = r_cnt_enable;
   assign bus.cnt_up_down = r_cnt_up_down;
   assign bus.cnt_reset   = r_cnt_reset;
   assign bus.busy        = ~w_idle;
   assign bus.done        = r_done;
   assign bus.done_id     = r_done_id;
   assign bus.done_value  = r_done_value;

endmodule

// File: tb/tb_updown_counter_scheduler.sv
module tb_updown_counter_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       ld;
   logic [3:0] ld_val;
   logic [3:0] cnt;
   int         checks = 0;
   int         errors = 0;

   updown_counter_scheduler_if #(.WIDTH(4), .STEP_W(4)) bus ();

   updown_counter_scheduler #(.WIDTH(4), .STEP_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Behavioural model of the shared counter instance; ld lets the bench preload it.
   always @(posedge clk) begin
      if (ld)                   cnt <= ld_val;
      else if (bus.cnt_reset)   cnt <= 4'h0;
      else if (bus.cnt_enable)  cnt <= bus.cnt_up_down ? cnt + 4'h1 : cnt - 4'h1;
   end
   assign bus.cnt_value = cnt;

   typedef struct {
      bit       id;
      bit       up;
      bit       clear;
      bit [3:0] steps;
      bit [3:0] pre;
      bit [3:0] exp_val;
      int       exp_lat;
      int       exp_en;
      int       exp_rst;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic set_req(input bit id, input bit v, input bit up, input bit clr,
                          input bit [3:0] steps);
      if (id) begin
         bus.req1_valid = v; bus.req1_up = up; bus.req1_clear = clr; bus.req1_steps = steps;
      end else begin
         bus.req0_valid = v; bus.req0_up = up; bus.req0_clear = clr; bus.req0_steps = steps;
      end
   endtask

   function automatic bit rdy(input bit id);
      return id ? bus.req1_ready : bus.req0_ready;
   endfunction

   task automatic preload(input bit [3:0] v);
      @(negedge clk); ld = 1'b1; ld_val = v;
      @(negedge clk); ld = 1'b0;
   endtask

   // Observes from just after a handshake edge until done; lat is the edge
   // index (relative to the handshake edge) at which done was registered.
   task automatic watch(input bit up, output bit seen, output int lat,
                        output int en_n, output int rst_n, output int bad_ud);
      seen = 0; lat = 0; en_n = 0; rst_n = 0; bad_ud = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.cnt_enable) begin
            en_n++;
            if (bus.cnt_up_down !== up) bad_ud++;
         end
         if (bus.cnt_reset) rst_n++;
         if (bus.done) begin
            seen = 1; lat = k - 1;
            break;
         end
      end
   endtask

   task automatic run_vec(input int n, input vec_t v);
      bit got, seen;
      int lat, en_n, rst_n, bad_ud;
      string tag;
      tag = $sformatf("v%0d", n);
      preload(v.pre);
      set_req(v.id, 1'b1, v.up, v.clear, v.steps);
      #1;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         if (rdy(v.id)) begin got = 1; break; end
         @(negedge clk); #1;
      end
      chk({tag, "_handshake"}, got, 1);
      @(posedge clk); #1;
      // Scramble the fields after acceptance; they must not matter now.
      set_req(v.id, 1'b0, ~v.up, ~v.clear, 4'hF);
      watch(v.up, seen, lat, en_n, rst_n, bad_ud);
      chk({tag, "_done_seen"}, seen, 1);
      chk({tag, "_latency"}, lat, v.exp_lat);
      chk({tag, "_done_id"}, bus.done_id, v.id);
      chk({tag, "_done_value"}, bus.done_value, v.exp_val);
      chk({tag, "_enable_cycles"}, en_n, v.exp_en);
      chk({tag, "_reset_cycles"}, rst_n, v.exp_rst);
      chk({tag, "_updown_wrong"}, bad_ud, 0);
      chk({tag, "_busy_at_done"}, bus.busy, 0);
   endtask

   initial begin
      bit seen;
      int lat, en_n, rst_n, bad_ud, dones;

      //          id up clr steps pre   val  lat en rst
      vecs[0] = '{1'b0, 1'b1, 1'b0, 4'd3,  4'h0, 4'h3, 4,  3,  0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 4'd3,  4'hE, 4'h1, 4,  3,  0};
      vecs[2] = '{1'b0, 1'b1, 1'b1, 4'd5,  4'h7, 4'h0, 2,  0,  1};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 4'd2,  4'h1, 4'hF, 3,  2,  0};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 4'd15, 4'h0, 4'hF, 16, 15, 0};
      vecs[5] = '{1'b0, 1'b0, 1'b0, 4'd0,  4'h5, 4'h5, 1,  0,  0};

      ld = 1'b0; ld_val = 4'h0; cnt = 4'h0;
      set_req(1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
      set_req(1'b1, 1'b1, 1'b1, 1'b0, 4'd3);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_done_id", bus.done_id, 0);
      chk("rst_done_value", bus.done_value, 0);
      chk("rst_cnt_ctrl", {bus.cnt_enable, bus.cnt_up_down, bus.cnt_reset}, 0);
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk); reset = 1'b0;

      // Simultaneous pair right after reset: req0 first, then req1.
      preload(4'h0);
      set_req(1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
      set_req(1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      #1;
      chk("pair_ready0", bus.req0_ready, 1);
      chk("pair_ready1", bus.req1_ready, 0);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      watch(1'b1, seen, lat, en_n, rst_n, bad_ud);
      chk("pair_a_seen", seen, 1);
      chk("pair_a_id", bus.done_id, 0);
      chk("pair_a_value", bus.done_value, 2);
      #1;
      chk("pair_b_ready1_at_done", bus.req1_ready, 1);
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      watch(1'b0, seen, lat, en_n, rst_n, bad_ud);
      chk("pair_b_seen", seen, 1);
      chk("pair_b_id", bus.done_id, 1);
      chk("pair_b_value", bus.done_value, 1);
      chk("pair_b_latency", lat, 2);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Last winner was req0, so a tie now goes to req1. Both then withdraw
      // before the edge: nothing must start.
      @(negedge clk);
      set_req(1'b0, 1'b1, 1'b1, 1'b0, 4'd1);
      set_req(1'b1, 1'b1, 1'b1, 1'b0, 4'd1);
      #1;
      chk("tie_ready0", bus.req0_ready, 0);
      chk("tie_ready1", bus.req1_ready, 1);
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      chk("withdraw_busy", bus.busy, 0);

      // Reset two cycles into a 6-step req0 command.
      preload(4'h0);
      set_req(1'b0, 1'b1, 1'b1, 1'b0, 4'd6);
      #1;
      chk("abort_ready0", bus.req0_ready, 1);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      @(negedge clk);
      chk("abort_enable_before", bus.cnt_enable, 1);
      reset = 1'b1;
      #1;
      chk("abort_enable", bus.cnt_enable, 0);
      chk("abort_busy", bus.busy, 0);
      @(negedge clk); reset = 1'b0;
      dones = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      chk("abort_no_done", dones, 0);
      set_req(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      set_req(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
      #1;
      chk("post_abort_ready0", bus.req0_ready, 1);
      chk("post_abort_ready1", bus.req1_ready, 0);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      set_req(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      watch(1'b0, seen, lat, en_n, rst_n, bad_ud);
      chk("post_abort_seen", seen, 1);
      chk("post_abort_id", bus.done_id, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
